ber_sync_meter: RTL and testbench
=================================

Name: ber_sync_meter

Overview:
- Multi-channel bit-error-rate meter for the QPSK receiver's slicer output. It generalises the per-rail I/Q error counter to NUM_CH channels.
- Each channel runs three steps on its own:
  - latency search: every delay of the local reference PRBS is tried against the received bits;
  - lock: the delay with the fewest errors is held;
  - count: error and total bits are accumulated into saturating counters.
- New behaviour compared with the current counter:
  - loss-of-lock detection with automatic re-sync;
  - a software clear;
  - a per-channel lock flag.
- It sits after the slicer and downsampler. Its outputs drive the LEDs and are probed hierarchically by the system bench.

Parameters:
- NUM_CH, 2, number of independent bit channels (I, Q, ...).
- PRBS_MAX_CYCLES, 511, reference delay-line depth; candidate latencies are 0..PRBS_MAX_CYCLES-1.
- SYNC_WINDOW, 511, valid bits compared per candidate latency and per lock-monitor window.
- UNLOCK_THR, 128, errors within one monitor window at or above which lock is dropped.
- NB_CNT, 64, width of the error and total counters.

Ports:
- clk, in, 1, system clock.
- i_reset, in, 1, synchronous, active-low reset.
- i_valid, in, 1, bit strobe; all channels sample on the same strobe.
- i_rx_bits, in, NUM_CH, received (sliced) bits; bit c belongs to channel c.
- i_ref_bits, in, NUM_CH, transmitter PRBS bits, qualified by i_valid.
- i_enable, in, 1, level signal; 0 freezes all state.
- i_clear, in, 1, one-cycle pulse: zero the counters and restart sync.
- o_locked, out, NUM_CH, channel is in COUNT state.
- o_lat, out, NUM_CH*$clog2(PRBS_MAX_CYCLES), chosen latency per channel; channel c occupies slice c.
- o_err_cnt, out, NUM_CH*NB_CNT, accumulated errors per channel.
- o_tot_cnt, out, NUM_CH*NB_CNT, accumulated compared bits per channel.

Behaviour:
- Reset (i_reset=0 at a clk edge):
  - all outputs go to 0;
  - delay lines are cleared;
  - every channel enters SEARCH with candidate latency 0.
- Delay line:
  - per channel, a PRBS_MAX_CYCLES-bit shift register loaded from i_ref_bits[c];
  - it shifts only when i_valid=1 and i_enable=1;
  - tap L means the reference delayed by L valid strobes.
- An error bit is rx XOR tap. It is registered, so counters update 1 cycle after the qualifying strobe.
- SEARCH state:
  - count errors at candidate L over SYNC_WINDOW strobes;
  - at window end, if the count is strictly below the best so far, record L as best (ties keep the lower L);
  - then increment L and clear the window count;
  - after L = PRBS_MAX_CYCLES-1, load o_lat with best and go to COUNT;
  - total search time is PRBS_MAX_CYCLES*SYNC_WINDOW strobes.
- COUNT state:
  - each strobe: tot += 1 and err += error bit, both saturating at 2^NB_CNT-1;
  - a monitor window count runs in parallel;
  - at the end of each SYNC_WINDOW, if window errors >= UNLOCK_THR, go to SEARCH, set L=0 and o_locked=0;
  - o_err_cnt and o_tot_cnt are held, not cleared, on loss of lock.
- o_locked is 1 exactly while the channel is in COUNT. It updates on the same edge as the state change.
- i_clear:
  - zeroes the counters, sets o_lat=0, and sends every channel to SEARCH with L=0;
  - it has priority over a simultaneous i_valid, and that bit is not counted;
  - delay-line contents are kept.
- i_enable=0 holds every register, including the delay line, regardless of i_valid.
- Reset has priority over i_clear.
- Reset mid-search or mid-count aborts immediately with no partial result.
- Channels are fully independent. One channel re-syncing does not disturb the others.

Decomposition:
- Shared package ber_pkg holds:
  - localparams for latency width ($clog2(PRBS_MAX_CYCLES)) and window-counter width ($clog2(SYNC_WINDOW+1));
  - state encoding SEARCH=1'b0, COUNT=1'b1.
- Sub-module ber_channel:
  - one per channel, created with a generate loop;
  - owns the delay line, FSM, window counters, best tracker and saturating counters.
- The top level only slices the vectors and broadcasts clk, i_reset, i_valid, i_enable and i_clear.

Test Plan:
- Ref = PRBS9 seed 9'h1AA; rx = ref delayed 37 strobes, error-free; i_valid every 4th cycle.
  - After 511*511 strobes, o_locked=2'b11 and o_lat=37 on both channels.
  - After a further 10000 strobes, err=0 and tot=10000.
- Channel 0 delayed 5, channel 1 delayed 300.
  - Independent locks with o_lat={300,5}.
  - Force channel 1 to invert its rx for one full window: only o_locked[1] drops, and channel 0's counts keep advancing.
- Lock, then flip every 100th rx bit for 20000 strobes.
  - err=200, tot=20000, lock retained (≈5 errors per window < UNLOCK_THR).
- Lock, then assert i_clear on the same cycle as i_valid.
  - Next cycle: err=0, tot=0, o_lat=0, o_locked=0.
  - The bit on the clear cycle is not counted.
- NB_CNT=4, locked, every rx bit inverted for 40 strobes with UNLOCK_THR=511.
  - err saturates at 15 and tot at 15; neither wraps.
- Hold i_enable=0 for 1000 strobes mid-search, then release.
  - Final o_lat is unchanged versus the uninterrupted run.
  - Assert i_reset=0 mid-count: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/ber_sync_meter_pkg.sv
// Shared definitions for the multi-channel BER meter: default sizing,
// width helpers and the per-channel state encoding.
// No ports; imported by the interface, the channel and the top.
package ber_pkg;

  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_PRBS_MAX_CYCLES = 511;
  localparam int DEF_SYNC_WINDOW     = 511;
  localparam int DEF_UNLOCK_THR      = 128;
  localparam int DEF_NB_CNT          = 64;

  // Width of a candidate latency (0..depth-1) and of a window counter (0..window).
  localparam int LAT_W = $clog2(DEF_PRBS_MAX_CYCLES);
  localparam int WIN_W = $clog2(DEF_SYNC_WINDOW + 1);

  function automatic int lat_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int win_w(input int window);
    return $clog2(window + 1);
  endfunction

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_COUNT  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/ber_sync_meter_if.sv
// Bit-stream and status bundle of the BER meter.
// Inputs: i_valid strobe, per-channel rx/ref bits, i_enable level, i_clear pulse.
// Outputs: per-channel lock flag, chosen latency, error and total counters.
interface ber_sync_meter_if
  import ber_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int PRBS_MAX_CYCLES = DEF_PRBS_MAX_CYCLES,
  parameter int NB_CNT          = DEF_NB_CNT
);
  localparam int LW = lat_w(PRBS_MAX_CYCLES);

  logic                     i_valid;
  logic [NUM_CH-1:0]        i_rx_bits;
  logic [NUM_CH-1:0]        i_ref_bits;
  logic                     i_enable;
  logic                     i_clear;
  logic [NUM_CH-1:0]        o_locked;
  logic [NUM_CH*LW-1:0]     o_lat;
  logic [NUM_CH*NB_CNT-1:0] o_err_cnt;
  logic [NUM_CH*NB_CNT-1:0] o_tot_cnt;

  modport master (
    output i_valid, i_rx_bits, i_ref_bits, i_enable, i_clear,
    input  o_locked, o_lat, o_err_cnt, o_tot_cnt
  );

  modport slave (
    input  i_valid, i_rx_bits, i_ref_bits, i_enable, i_clear,
    output o_locked, o_lat, o_err_cnt, o_tot_cnt
  );
endinterface

// File: rtl/ber_sync_meter_channel.sv
// One BER channel: latency search over the reference delay line, lock, and
// saturating error/total counting with loss-of-lock re-sync.
// Latency: counters update one cycle after the strobe. No backpressure; i_enable=0 freezes all state.
// Ports: clk, i_reset (sync, active low), i_valid/i_enable/i_clear controls, i_rx/i_ref bits,
//        o_locked, o_lat, o_err_cnt, o_tot_cnt.
module ber_channel
  import ber_pkg::*;
#(
  parameter int PRBS_MAX_CYCLES = DEF_PRBS_MAX_CYCLES,
  parameter int SYNC_WINDOW     = DEF_SYNC_WINDOW,
  parameter int UNLOCK_THR      = DEF_UNLOCK_THR,
  parameter int NB_CNT          = DEF_NB_CNT,
  localparam int LW             = lat_w(PRBS_MAX_CYCLES)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_enable,
  input  logic              i_clear,
  input  logic              i_rx,
  input  logic              i_ref,
  output logic              o_locked,
  output logic [LW-1:0]     o_lat,
  output logic [NB_CNT-1:0] o_err_cnt,
  output logic [NB_CNT-1:0] o_tot_cnt
);
  localparam int WW = win_w(SYNC_WINDOW);
  localparam logic [LW-1:0] LAT_LAST = LW'(PRBS_MAX_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(SYNC_WINDOW - 1);

  // Tap 0 is the live reference bit, so the register holds depth-1 older bits.
  logic [PRBS_MAX_CYCLES-2:0] dl_q, dl_d;
  logic [PRBS_MAX_CYCLES-1:0] taps;
  logic [LW-1:0]              tap_sel;

  ch_state_e         state_q, state_d;
  logic              err_bit_q, err_bit_d;
  logic              err_vld_q, err_vld_d;
  logic [LW-1:0]     cand_q, cand_d;
  logic [LW-1:0]     best_lat_q, best_lat_d;
  logic [WW-1:0]     best_err_q, best_err_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [WW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     win_err_q, win_err_d;
  logic [NB_CNT-1:0] err_cnt_q, err_cnt_d;
  logic [NB_CNT-1:0] tot_cnt_q, tot_cnt_d;

  logic [WW-1:0] win_err_nxt;
  logic          win_last;
  logic          better;

  assign taps        = {dl_q, i_ref};
  assign tap_sel     = (state_q == ST_COUNT) ? lat_q : cand_q;
  assign win_err_nxt = win_err_q + WW'(err_bit_q);
  assign win_last    = (bit_cnt_q == WIN_LAST);
  assign better      = (win_err_nxt < best_err_q);

  always_comb begin
    dl_d       = dl_q;
    state_d    = state_q;
    err_bit_d  = err_bit_q;
    err_vld_d  = err_vld_q;
    cand_d     = cand_q;
    best_lat_d = best_lat_q;
    best_err_d = best_err_q;
    lat_d      = lat_q;
    bit_cnt_d  = bit_cnt_q;
    win_err_d  = win_err_q;
    err_cnt_d  = err_cnt_q;
    tot_cnt_d  = tot_cnt_q;

    if (i_enable) begin
      // A strobe coinciding with a clear is dropped entirely.
      err_vld_d = i_valid & ~i_clear;
      err_bit_d = i_rx ^ taps[tap_sel];
      if (i_valid && !i_clear) begin
        dl_d = taps[PRBS_MAX_CYCLES-2:0];
      end

      if (i_clear) begin
        state_d    = ST_SEARCH;
        cand_d     = '0;
        best_lat_d = '0;
        best_err_d = '1;
        lat_d      = '0;
        bit_cnt_d  = '0;
        win_err_d  = '0;
        err_cnt_d  = '0;
        tot_cnt_d  = '0;
      end else if (err_vld_q) begin
        bit_cnt_d = win_last ? '0 : bit_cnt_q + 1'b1;
        win_err_d = win_last ? '0 : win_err_nxt;

        case (state_q)
          ST_SEARCH: begin
            if (win_last) begin
              // Strict compare: on a tie the lower latency already recorded wins.
              if (better) begin
                best_err_d = win_err_nxt;
                best_lat_d = cand_q;
              end
              if (cand_q == LAT_LAST) begin
                state_d    = ST_COUNT;
                lat_d      = better ? cand_q : best_lat_q;
                cand_d     = '0;
                best_lat_d = '0;
                best_err_d = '1;
              end else begin
                cand_d = cand_q + 1'b1;
              end
            end
          end
          ST_COUNT: begin
            if (err_bit_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
            if (tot_cnt_q != '1)                tot_cnt_d = tot_cnt_q + 1'b1;
            // Counters are held across loss of lock; only the search restarts.
            if (win_last && (32'(win_err_nxt) >= UNLOCK_THR)) begin
              state_d = ST_SEARCH;
              cand_d  = '0;
            end
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      dl_q       <= '0;
      state_q    <= ST_SEARCH;
      err_bit_q  <= 1'b0;
      err_vld_q  <= 1'b0;
      cand_q     <= '0;
      best_lat_q <= '0;
      best_err_q <= '1;
      lat_q      <= '0;
      bit_cnt_q  <= '0;
      win_err_q  <= '0;
      err_cnt_q  <= '0;
      tot_cnt_q  <= '0;
    end else begin
      dl_q       <= dl_d;
      state_q    <= state_d;
      err_bit_q  <= err_bit_d;
      err_vld_q  <= err_vld_d;
      cand_q     <= cand_d;
      best_lat_q <= best_lat_d;
      best_err_q <= best_err_d;
      lat_q      <= lat_d;
      bit_cnt_q  <= bit_cnt_d;
      win_err_q  <= win_err_d;
      err_cnt_q  <= err_cnt_d;
      tot_cnt_q  <= tot_cnt_d;
    end
  end

  assign o_locked  = (state_q == ST_COUNT);
  assign o_lat     = lat_q;
  assign o_err_cnt = err_cnt_q;
  assign o_tot_cnt = tot_cnt_q;

endmodule

// File: rtl/ber_sync_meter.sv
// Multi-channel BER meter: NUM_CH independent ber_channel instances on a shared strobe.
// Latency: counters update one cycle after the strobe. No backpressure; i_enable=0 freezes all state.
// Ports: clk, i_reset (sync, active low), bus (slave modport carrying bits, controls and status).
module ber_sync_meter
  import ber_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int PRBS_MAX_CYCLES = DEF_PRBS_MAX_CYCLES,
  parameter int SYNC_WINDOW     = DEF_SYNC_WINDOW,
  parameter int UNLOCK_THR      = DEF_UNLOCK_THR,
  parameter int NB_CNT          = DEF_NB_CNT
) (
  input  logic             clk,
  input  logic             i_reset,
  ber_sync_meter_if.slave  bus
);
  localparam int LW = lat_w(PRBS_MAX_CYCLES);

  logic [NUM_CH-1:0]        locked;
  logic [NUM_CH*LW-1:0]     lat;
  logic [NUM_CH*NB_CNT-1:0] err_cnt;
  logic [NUM_CH*NB_CNT-1:0] tot_cnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ber_channel #(
      .PRBS_MAX_CYCLES (PRBS_MAX_CYCLES),
      .SYNC_WINDOW     (SYNC_WINDOW),
      .UNLOCK_THR      (UNLOCK_THR),
      .NB_CNT          (NB_CNT)
    ) u_ch (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_valid   (bus.i_valid),
      .i_enable  (bus.i_enable),
      .i_clear   (bus.i_clear),
      .i_rx      (bus.i_rx_bits[c]),
      .i_ref     (bus.i_ref_bits[c]),
      .o_locked  (locked[c]),
      .o_lat     (lat[c*LW +: LW]),
      .o_err_cnt (err_cnt[c*NB_CNT +: NB_CNT]),
      .o_tot_cnt (tot_cnt[c*NB_CNT +: NB_CNT])
    );
  end

  assign bus.o_locked  = locked;
  assign bus.o_lat     = lat;
  assign bus.o_err_cnt = err_cnt;
  assign bus.o_tot_cnt = tot_cnt;

endmodule

// File: tb/tb_ber_sync_meter.sv
// Directed bench for ber_sync_meter, scaled down (16-deep delay line, 32-bit windows).
// dut_a: 16-bit counters, unlock at 8 errors/window. dut_b: 4-bit counters, never unlocks.
// Stimulus: PRBS9 (seed 9'h1AA) reference, rx = reference delayed 5 (ch0) / 12 (ch1).
module tb_ber_sync_meter;
  localparam int P  = 16;
  localparam int W  = 32;
  localparam int NA = 16;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, enable, clear;
  logic [1:0] ref_bits, rx_a, rx_b;

  logic [8:0]  lfsr;
  logic [63:0] hist;
  int          d_ch [2] = '{5, 12};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ber_sync_meter_if #(.NUM_CH(2), .PRBS_MAX_CYCLES(P), .NB_CNT(NA)) bus_a ();
  ber_sync_meter_if #(.NUM_CH(2), .PRBS_MAX_CYCLES(P), .NB_CNT(NB)) bus_b ();

  assign bus_a.i_valid    = valid;
  assign bus_a.i_enable   = enable;
  assign bus_a.i_clear    = clear;
  assign bus_a.i_ref_bits = ref_bits;
  assign bus_a.i_rx_bits  = rx_a;
  assign bus_b.i_valid    = valid;
  assign bus_b.i_enable   = enable;
  assign bus_b.i_clear    = clear;
  assign bus_b.i_ref_bits = ref_bits;
  assign bus_b.i_rx_bits  = rx_b;

  ber_sync_meter #(.NUM_CH(2), .PRBS_MAX_CYCLES(P), .SYNC_WINDOW(W),
                   .UNLOCK_THR(8), .NB_CNT(NA))
    dut_a (.clk(clk), .i_reset(rst_n), .bus(bus_a));

  ber_sync_meter #(.NUM_CH(2), .PRBS_MAX_CYCLES(P), .SYNC_WINDOW(W),
                   .UNLOCK_THR(W + 1), .NB_CNT(NB))
    dut_b (.clk(clk), .i_reset(rst_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present the next PRBS bit; adv=0 replays it without advancing the stream.
  task automatic strobe(input logic [1:0] inv_a, input logic [1:0] inv_b, input bit adv);
    logic        nb;
    logic [64:0] full;
    nb   = lfsr[8] ^ lfsr[4];
    full = {hist, nb};
    @(negedge clk);
    ref_bits = {nb, nb};
    for (int c = 0; c < 2; c++) begin
      rx_a[c] = full[d_ch[c]] ^ inv_a[c];
      rx_b[c] = full[d_ch[c]] ^ inv_b[c];
    end
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    if (adv) begin
      lfsr = {lfsr[7:0], nb};
      hist = full[63:0];
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) strobe(2'b00, 2'b00, 1'b1);
  endtask

  initial begin
    logic        nb;
    logic [64:0] full;
    lfsr = 9'h1AA;
    hist = '0;
    rst_n = 1'b0; valid = 1'b0; enable = 1'b1; clear = 1'b0;
    ref_bits = '0; rx_a = '0; rx_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_locked", 64'(bus_a.o_locked), 64'd0);
    chk("rst_lat",    64'(bus_a.o_lat), 64'd0);
    chk("rst_err",    bus_a.o_err_cnt, 64'd0);
    chk("rst_tot",    bus_a.o_tot_cnt, 64'd0);
    rst_n = 1'b1;

    // Full search: P*W strobes; still searching one strobe before the end.
    run(P * W - 1);
    chk("pre_lock", 64'(bus_a.o_locked), 64'd0);
    run(1);
    chk("lock",     64'(bus_a.o_locked), 64'd3);
    chk("lock_lat", 64'(bus_a.o_lat), 64'hC5);

    // dut_b sees every bit inverted: 4-bit counters must stick at 15.
    for (int i = 0; i < 40; i++) strobe(2'b00, 2'b11, 1'b1);
    chk("sat_err_b", 64'(bus_b.o_err_cnt[3:0]), 64'd15);
    chk("sat_tot_b", 64'(bus_b.o_tot_cnt[3:0]), 64'd15);
    chk("clean_err", bus_a.o_err_cnt[15:0], 64'd0);
    chk("clean_tot", bus_a.o_tot_cnt[15:0], 64'd40);

    // Every 10th bit flipped on both channels: at most 4 errors/window, lock kept.
    for (int k = 0; k < 200; k++) begin
      if (k % 10 == 9) strobe(2'b11, 2'b11, 1'b1);
      else             strobe(2'b00, 2'b00, 1'b1);
    end
    chk("sparse_err0", bus_a.o_err_cnt[15:0],  64'd20);
    chk("sparse_tot0", bus_a.o_tot_cnt[15:0],  64'd240);
    chk("sparse_err1", bus_a.o_err_cnt[31:16], 64'd20);
    chk("sparse_lock", 64'(bus_a.o_locked), 64'd3);

    // Invert ch1 for one window length; lock drops at the window ending at bit 256.
    for (int i = 0; i < W; i++) strobe(2'b10, 2'b00, 1'b1);
    chk("unlock1",   64'(bus_a.o_locked), 64'd1);
    chk("ch0_tot",   bus_a.o_tot_cnt[15:0],  64'd272);
    chk("ch0_err",   bus_a.o_err_cnt[15:0],  64'd20);
    chk("ch1_err_h", bus_a.o_err_cnt[31:16], 64'd36);
    chk("ch1_tot_h", bus_a.o_tot_cnt[31:16], 64'd256);

    // Clear coinciding with a strobe; the strobe is dropped by the DUT and the model.
    nb   = lfsr[8] ^ lfsr[4];
    full = {hist, nb};
    @(negedge clk);
    ref_bits = {nb, nb};
    rx_a = {full[d_ch[1]], full[d_ch[0]]};
    rx_b = rx_a;
    valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
    chk("clr_err",    bus_a.o_err_cnt, 64'd0);
    chk("clr_tot",    bus_a.o_tot_cnt, 64'd0);
    chk("clr_lat",    64'(bus_a.o_lat), 64'd0);
    chk("clr_locked", 64'(bus_a.o_locked), 64'd0);
    repeat (2) @(negedge clk);

    // Re-search with a 100-strobe enable=0 pause in the middle.
    run(P * W / 2);
    enable = 1'b0;
    for (int i = 0; i < 100; i++) strobe(2'b00, 2'b00, 1'b0);
    chk("pause_locked", 64'(bus_a.o_locked), 64'd0);
    enable = 1'b1;
    run(P * W / 2 - 1);
    chk("pause_pre_lock", 64'(bus_a.o_locked), 64'd0);
    run(1);
    chk("relock",     64'(bus_a.o_locked), 64'd3);
    chk("relock_lat", 64'(bus_a.o_lat), 64'hC5);

    run(50);
    chk("cnt_tot", bus_a.o_tot_cnt, {16'd0, 16'd0, 16'd50, 16'd50});
    chk("cnt_err", bus_a.o_err_cnt, 64'd0);

    // Reset mid-count: everything back to zero after one edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_locked", 64'(bus_a.o_locked), 64'd0);
    chk("mid_rst_lat",    64'(bus_a.o_lat), 64'd0);
    chk("mid_rst_err",    bus_a.o_err_cnt, 64'd0);
    chk("mid_rst_tot",    bus_a.o_tot_cnt, 64'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
